// File: rtl/itch_add_order_decoder.sv
// ITCH 5.0 Add Order ('A') byte-serial decoder; fields load speculatively.
// Optional macro SIDE_CHECK_EN rejects side bytes other than 'B'/'S'.
module itch_add_order_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        valid_in,
    output logic        internal_valid,
    output logic        packet_invalid,
    output logic [63:0] order_ref,
    output logic        side,
    output logic [31:0] shares,
    output logic [63:0] price,
    output logic [31:0] timestamp,
    output logic [63:0] misc_data
);

    localparam logic [7:0] TYPE_A   = 8'h41;
    localparam logic [7:0] SIDE_B   = 8'h42;
    localparam logic [7:0] SIDE_S   = 8'h53;
    localparam logic [5:0] SIDE_IDX = 6'd19;
    localparam logic [5:0] LAST_IDX = 6'd35;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PARSE,
        S_SKIP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_idx;
    logic [5:0]  w_idx_nxt;
    logic        w_iv_nxt;
    logic        w_pi_nxt;
    logic        w_side_ok;
    logic        w_load;

    logic        r_iv;
    logic        r_pi;
    logic [63:0] r_order_ref;
    logic        r_side;
    logic [31:0] r_shares;
    logic [31:0] r_price;
    logic [31:0] r_timestamp;
    logic [63:0] r_misc;

`ifdef SIDE_CHECK_EN
    assign w_side_ok = (byte_in == SIDE_B) || (byte_in == SIDE_S);
`else
    assign w_side_ok = 1'b1;
`endif

    assign w_load = (r_state == S_PARSE) && valid_in;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_iv_nxt    = 1'b0;
        w_pi_nxt    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (valid_in) begin
                    if (byte_in == TYPE_A) begin
                        w_state_nxt = S_PARSE;
                        w_idx_nxt   = 6'd1;
                    end else begin
                        w_state_nxt = S_SKIP;
                        w_idx_nxt   = 6'd0;
                        w_pi_nxt    = 1'b1;
                    end
                end
            end
            S_PARSE: begin
                if (!valid_in) begin
                    // Bytes must be contiguous; a gap kills the message
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = 6'd0;
                    w_pi_nxt    = 1'b1;
                end else if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = 6'd0;
                    w_iv_nxt    = 1'b1;
                end else if (r_idx == SIDE_IDX && !w_side_ok) begin
                    w_state_nxt = S_SKIP;
                    w_idx_nxt   = 6'd0;
                    w_pi_nxt    = 1'b1;
                end else begin
                    w_idx_nxt   = r_idx + 6'd1;
                end
            end
            S_SKIP: begin
                if (!valid_in) begin
                    w_state_nxt = S_IDLE;
                end
                w_idx_nxt = 6'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_idx   <= 6'd0;
            r_iv    <= 1'b0;
            r_pi    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_iv    <= w_iv_nxt;
            r_pi    <= w_pi_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_order_ref <= 64'd0;
            r_side      <= 1'b0;
            r_shares    <= 32'd0;
            r_price     <= 32'd0;
            r_timestamp <= 32'd0;
            r_misc      <= 64'd0;
        end else if (w_load) begin
            // Locate, tracking and timestamp high bytes (1..6) are dropped
            unique case (1'b1)
                (r_idx >= 6'd7 && r_idx <= 6'd10):
                    r_timestamp <= {r_timestamp[23:0], byte_in};
                (r_idx >= 6'd11 && r_idx <= 6'd18):
                    r_order_ref <= {r_order_ref[55:0], byte_in};
                (r_idx == SIDE_IDX):
                    r_side <= (byte_in == SIDE_B);
                (r_idx >= 6'd20 && r_idx <= 6'd23):
                    r_shares <= {r_shares[23:0], byte_in};
                (r_idx >= 6'd24 && r_idx <= 6'd31):
                    r_misc <= {r_misc[55:0], byte_in};
                (r_idx >= 6'd32 && r_idx <= 6'd35):
                    r_price <= {r_price[23:0], byte_in};
                default: begin
                end
            endcase
        end
    end

    assign internal_valid = r_iv;
    assign packet_invalid = r_pi;
    assign order_ref      = r_order_ref;
    assign side           = r_side;
    assign shares         = r_shares;
    assign price          = {32'd0, r_price};
    assign timestamp      = r_timestamp;
    assign misc_data      = r_misc;

endmodule

// File: tb/tb_itch_add_order_decoder.sv
// Directed bench for itch_add_order_decoder.
// Expectation for the bad-side case follows SIDE_CHECK_EN.
module tb_itch_add_order_decoder;

    logic        clk;
    logic        rst;
    logic [7:0]  byte_in;
    logic        valid_in;
    logic        internal_valid;
    logic        packet_invalid;
    logic [63:0] order_ref;
    logic        side;
    logic [31:0] shares;
    logic [63:0] price;
    logic [31:0] timestamp;
    logic [63:0] misc_data;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int iv_cnt = 0;
    int pi_cnt = 0;
    int both_cnt = 0;
    int iv_cyc = -1;
    int iv_cyc_prev = -1;
    int pi_cyc = -1;
    logic [63:0] s_oref;
    logic        s_side;
    logic [31:0] s_shares;
    logic [63:0] s_price;
    logic [31:0] s_ts;
    logic [63:0] s_misc;

    logic [7:0] msg [36];
    int         sent_cyc [36];

    itch_add_order_decoder dut (
        .clk            (clk),
        .rst            (rst),
        .byte_in        (byte_in),
        .valid_in       (valid_in),
        .internal_valid (internal_valid),
        .packet_invalid (packet_invalid),
        .order_ref      (order_ref),
        .side           (side),
        .shares         (shares),
        .price          (price),
        .timestamp      (timestamp),
        .misc_data      (misc_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (internal_valid) begin
            iv_cnt      = iv_cnt + 1;
            iv_cyc_prev = iv_cyc;
            iv_cyc      = cyc;
            s_oref      = order_ref;
            s_side      = side;
            s_shares    = shares;
            s_price     = price;
            s_ts        = timestamp;
            s_misc      = misc_data;
        end
        if (packet_invalid) begin
            pi_cnt = pi_cnt + 1;
            pi_cyc = cyc;
        end
        if (internal_valid && packet_invalid) both_cnt = both_cnt + 1;
    end

    task automatic build_msg(input logic [7:0] typ, input logic [7:0] sd,
                             input logic [31:0] sh);
        msg[0]  = typ;
        msg[1]  = 8'h00; msg[2]  = 8'h07;
        msg[3]  = 8'h00; msg[4]  = 8'h2A;
        msg[5]  = 8'h00; msg[6]  = 8'h00;
        msg[7]  = 8'h12; msg[8]  = 8'h34;
        msg[9]  = 8'h56; msg[10] = 8'h78;
        for (int i = 0; i < 8; i++) msg[11+i] = 8'(i + 1);
        msg[19] = sd;
        msg[20] = sh[31:24]; msg[21] = sh[23:16];
        msg[22] = sh[15:8];  msg[23] = sh[7:0];
        msg[24] = 8'h41; msg[25] = 8'h41;
        msg[26] = 8'h50; msg[27] = 8'h4C;
        msg[28] = 8'h20; msg[29] = 8'h20;
        msg[30] = 8'h20; msg[31] = 8'h20;
        msg[32] = 8'h00; msg[33] = 8'h16;
        msg[34] = 8'hE3; msg[35] = 8'h60;
    endtask

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            byte_in     = msg[i];
            valid_in    = 1'b1;
            sent_cyc[i] = cyc + 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0;
            byte_in  = 8'h00;
        end
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        valid_in = 1'b0;
        byte_in  = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({internal_valid, packet_invalid, order_ref, side, shares,
             price, timestamp, misc_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero outputs, required all 0");
        end
        rst = 1'b1;
        idle(3);
        checks++;
        if (iv_cnt !== 0 || pi_cnt !== 0) begin
            errors++;
            $display("FAIL reset_no_pulse: iv=%0d pi=%0d required 0 0",
                     iv_cnt, pi_cnt);
        end
    endtask

    task automatic check_good(input string nm, input logic exp_side,
                              input logic [31:0] exp_sh);
        checks++;
        if (iv_cyc !== sent_cyc[35]) begin
            errors++;
            $display("FAIL %s_latency: got cycle %0d required %0d",
                     nm, iv_cyc, sent_cyc[35]);
        end
        checks++;
        if (s_ts !== 32'h12345678 || s_oref !== 64'h0102030405060708) begin
            errors++;
            $display("FAIL %s_ts_oref: got %h %h required 12345678 0102030405060708",
                     nm, s_ts, s_oref);
        end
        checks++;
        if (s_side !== exp_side || s_shares !== exp_sh) begin
            errors++;
            $display("FAIL %s_side_shares: got %b %h required %b %h",
                     nm, s_side, s_shares, exp_side, exp_sh);
        end
        checks++;
        if (s_misc !== 64'h4141504C20202020 || s_price !== 64'h16E360) begin
            errors++;
            $display("FAIL %s_misc_price: got %h %h required 4141504C20202020 000000000016E360",
                     nm, s_misc, s_price);
        end
    endtask

    task automatic test_valid();
        int iv0, pi0;
        iv0 = iv_cnt; pi0 = pi_cnt;
        build_msg(8'h41, 8'h42, 32'd100);
        send_bytes(36);
        idle(3);
        checks++;
        if (iv_cnt - iv0 !== 1 || pi_cnt - pi0 !== 0) begin
            errors++;
            $display("FAIL valid_pulses: iv=%0d pi=%0d required 1 0",
                     iv_cnt - iv0, pi_cnt - pi0);
        end
        check_good("valid", 1'b1, 32'd100);
    endtask

    task automatic test_back_to_back();
        int iv0, pi0, c1;
        iv0 = iv_cnt; pi0 = pi_cnt;
        build_msg(8'h41, 8'h42, 32'd100);
        send_bytes(36);
        c1 = sent_cyc[35];
        build_msg(8'h41, 8'h53, 32'd200);
        send_bytes(36);
        idle(3);
        checks++;
        if (iv_cnt - iv0 !== 2 || pi_cnt - pi0 !== 0) begin
            errors++;
            $display("FAIL b2b_pulses: iv=%0d pi=%0d required 2 0",
                     iv_cnt - iv0, pi_cnt - pi0);
        end
        checks++;
        if (iv_cyc_prev !== c1 || iv_cyc - iv_cyc_prev !== 36) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d,%0d required %0d,%0d",
                     iv_cyc_prev, iv_cyc, c1, c1 + 36);
        end
        check_good("b2b", 1'b0, 32'd200);
    endtask

    task automatic test_wrong_type();
        int iv0, pi0;
        iv0 = iv_cnt; pi0 = pi_cnt;
        build_msg(8'h45, 8'h42, 32'd100);
        send_bytes(36);
        idle(1);
        checks++;
        if (pi_cnt - pi0 !== 1 || pi_cyc !== sent_cyc[0] ||
            iv_cnt - iv0 !== 0) begin
            errors++;
            $display("FAIL wrong_type: pi=%0d at %0d iv=%0d required 1 at %0d iv=0",
                     pi_cnt - pi0, pi_cyc, iv_cnt - iv0, sent_cyc[0]);
        end
        build_msg(8'h41, 8'h53, 32'd300);
        send_bytes(36);
        idle(3);
        checks++;
        if (iv_cnt - iv0 !== 1 || pi_cnt - pi0 !== 1) begin
            errors++;
            $display("FAIL wrong_type_recover: iv=%0d pi=%0d required 1 1",
                     iv_cnt - iv0, pi_cnt - pi0);
        end
        check_good("wt_next", 1'b0, 32'd300);
    endtask

    task automatic test_gap_abort();
        int iv0, pi0, gap_cyc;
        iv0 = iv_cnt; pi0 = pi_cnt;
        build_msg(8'h41, 8'h42, 32'd100);
        send_bytes(21);
        @(negedge clk);
        valid_in = 1'b0;
        gap_cyc  = cyc + 1;
        idle(3);
        checks++;
        if (pi_cnt - pi0 !== 1 || pi_cyc !== gap_cyc ||
            iv_cnt - iv0 !== 0) begin
            errors++;
            $display("FAIL gap_abort: pi=%0d at %0d iv=%0d required 1 at %0d iv=0",
                     pi_cnt - pi0, pi_cyc, iv_cnt - iv0, gap_cyc);
        end
        build_msg(8'h41, 8'h42, 32'h01020304);
        send_bytes(36);
        idle(3);
        checks++;
        if (iv_cnt - iv0 !== 1 || pi_cnt - pi0 !== 1) begin
            errors++;
            $display("FAIL gap_recover: iv=%0d pi=%0d required 1 1",
                     iv_cnt - iv0, pi_cnt - pi0);
        end
        check_good("gap_next", 1'b1, 32'h01020304);
    endtask

    task automatic test_side_check();
        int iv0, pi0;
        iv0 = iv_cnt; pi0 = pi_cnt;
        build_msg(8'h41, 8'h58, 32'd100);
        send_bytes(36);
        idle(3);
`ifdef SIDE_CHECK_EN
        checks++;
        if (pi_cnt - pi0 !== 1 || pi_cyc !== sent_cyc[19] ||
            iv_cnt - iv0 !== 0) begin
            errors++;
            $display("FAIL side_check: pi=%0d at %0d iv=%0d required 1 at %0d iv=0",
                     pi_cnt - pi0, pi_cyc, iv_cnt - iv0, sent_cyc[19]);
        end
`else
        checks++;
        if (iv_cnt - iv0 !== 1 || pi_cnt - pi0 !== 0) begin
            errors++;
            $display("FAIL side_nocheck: iv=%0d pi=%0d required 1 0",
                     iv_cnt - iv0, pi_cnt - pi0);
        end
        check_good("side_x", 1'b0, 32'd100);
`endif
    endtask

    task automatic test_reset_mid();
        int iv0, pi0;
        build_msg(8'h41, 8'h42, 32'd100);
        send_bytes(15);
        @(negedge clk);
        iv0 = iv_cnt; pi0 = pi_cnt;
        rst      = 1'b0;
        valid_in = 1'b0;
        byte_in  = 8'h00;
        #1;
        checks++;
        if ({internal_valid, packet_invalid, order_ref, side, shares,
             price, timestamp, misc_data} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got nonzero outputs, required all 0");
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(4);
        checks++;
        if (iv_cnt - iv0 !== 0 || pi_cnt - pi0 !== 0) begin
            errors++;
            $display("FAIL rst_mid_pulse: iv=%0d pi=%0d required 0 0",
                     iv_cnt - iv0, pi_cnt - pi0);
        end
        build_msg(8'h41, 8'h53, 32'd200);
        send_bytes(36);
        idle(3);
        checks++;
        if (iv_cnt - iv0 !== 1 || pi_cnt - pi0 !== 0) begin
            errors++;
            $display("FAIL rst_mid_recover: iv=%0d pi=%0d required 1 0",
                     iv_cnt - iv0, pi_cnt - pi0);
        end
        check_good("rst_next", 1'b0, 32'd200);
    endtask

    task automatic test_exclusive();
        checks++;
        if (both_cnt !== 0) begin
            errors++;
            $display("FAIL pulse_overlap: got %0d cycles, required 0", both_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_valid();
        test_back_to_back();
        test_wrong_type();
        test_gap_abort();
        test_side_check();
        test_reset_mid();
        test_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/itch_add_order_decoder.md
# itch_add_order_decoder

Byte-serial decoder for the NASDAQ ITCH 5.0 Add Order ('A') message, 36 bytes. It sits directly behind the byte stream of the ITCH packet front end. Fields are written into the output registers speculatively as each byte arrives. A one-cycle `internal_valid` pulse marks a complete, well-formed message. A one-cycle `packet_invalid` pulse marks a rejected or aborted message.

## Interface
- No parameters.
- `clk` in 1: single clock; all logic samples on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `byte_in` in 8: message byte, big-endian field order.
- `valid_in` in 1: `byte_in` is accepted on any rising edge where this is high. Bytes of one message are contiguous.
- `internal_valid` out 1: one-cycle pulse; all fields below are coherent for a complete message.
- `packet_invalid` out 1: one-cycle pulse; the current message is rejected.
- `order_ref` out 64: order reference number, bytes 11–18.
- `side` out 1: byte 19; 1 = 'B' (0x42) buy, 0 = otherwise.
- `shares` out 32: bytes 20–23.
- `price` out 64: bytes 32–35 in bits [31:0]; bits [63:32] are always 0.
- `timestamp` out 32: low 32 bits of the 48-bit timestamp, bytes 7–10. Bytes 5–6 are discarded.
- `misc_data` out 64: 8-byte stock symbol, bytes 24–31. Byte 24 is in bits [63:56].

## Operation
- Byte index layout:
  - 0: type
  - 1–2: stock locate
  - 3–4: tracking number
  - 5–10: timestamp
  - 11–18: order ref
  - 19: side
  - 20–23: shares
  - 24–31: stock
  - 32–35: price
- Bytes 1–4 are consumed and dropped.
- The state machine has three states: IDLE, PARSE and SKIP. A 6-bit byte counter `idx` tracks position in the message.
- IDLE:
  - On an accepted byte equal to 0x41: go to PARSE with `idx`=1.
  - On an accepted byte not equal to 0x41: pulse `packet_invalid` and go to SKIP.
- PARSE:
  - Each accepted byte is shifted into its field register, then `idx` increments. Shifting is `field <= {field[n-9:0], byte_in}`, so multi-byte fields are big-endian.
  - On the byte at `idx`=35: pulse `internal_valid` and return to IDLE. A byte on the very next cycle starts a new message (back-to-back support).
  - If `valid_in` is low while `idx` is in 1..35: pulse `packet_invalid` and go to IDLE. The gap aborts the message.
- SKIP:
  - Discard bytes while `valid_in` is high.
  - Go to IDLE on the first cycle `valid_in` is low. No pulse is generated.
- Field registers hold their last written value. Between pulses they may contain partial data from an in-progress or aborted message. Consumers qualify them with `internal_valid` only.
- `internal_valid` and `packet_invalid` are never high in the same cycle.

## Timing
- All outputs are registered.
- Reset values: every output is 0, state is IDLE, `idx` is 0.
- Reset asserted mid-message: the message is discarded immediately. No pulse is generated after release.
- Latency: `internal_valid` is high in the cycle after byte 35 is sampled, with all fields already holding final values.
- The minimum message time is 36 cycles. Sustained throughput is one message per 36 cycles.
- `packet_invalid` is high in the cycle after the offending sample: the bad type byte, the gap cycle, or the bad side byte.
- The block has no backpressure. The upstream source must tolerate a byte being dropped in SKIP.

## Configuration
- `SIDE_CHECK_EN` defined:
  - The byte at `idx`=19 must be 0x42 ('B') or 0x53 ('S').
  - Any other value pulses `packet_invalid` in the next cycle and goes to SKIP.
- `SIDE_CHECK_EN` undefined:
  - There is no side check; `side` = (byte==0x42).
  - A bad side byte never causes rejection.

## Test plan
- Valid message: type 0x41, timestamp 0x0000_1234_5678, order_ref 0x0102030405060708, side 'B', shares 100, stock "AAPL    ", price 1500000. Required response:
  - `internal_valid` pulses exactly once, one cycle after byte 35.
  - `timestamp`=0x12345678, `order_ref`=0x0102030405060708, `side`=1, `shares`=0x64.
  - `misc_data`=0x4141504C20202020, `price`=0x00000000_0016E360.
- Back-to-back: two valid messages with zero idle cycles, the second with side 'S' and shares 200. Required response:
  - Two `internal_valid` pulses 36 cycles apart.
  - The second pulse shows `side`=0 and `shares`=200.
- Wrong type: a 36-byte burst starting 0x45. Required response:
  - `packet_invalid` pulses once, in the cycle after byte 0.
  - No `internal_valid`.
  - A following valid message decodes correctly.
- Gap abort: `valid_in` deasserted for one cycle after byte 20. Required response:
  - `packet_invalid` pulses once.
  - No `internal_valid`.
  - The next full message decodes correctly.
- Side check with `SIDE_CHECK_EN` defined: side byte 0x58. Required response:
  - `packet_invalid` pulses the cycle after byte 19.
  - No `internal_valid`.
  - Without the macro, the same message gives `internal_valid` with `side`=0.
- Reset mid-message: assert `rst` low at byte 15 of a message. Required response:
  - All outputs read 0 while `rst` is low.
  - No pulse after release.
  - A subsequent valid message decodes correctly.
